// File: rtl/trigger_run_controller.sv
// rtl/trigger_run_controller.sv - run-control sequencer for one data_trigger channel
module trigger_run_controller #(
  parameter int MAX_PRE_ACQUISITION_LENGTH  = 2,
  parameter int MAX_POST_ACQUISITION_LENGTH = 2,
  parameter int SAMPLE_WIDTH                = 16,
  parameter int DRAIN_IDLE_CYCLES           = 8,
  parameter int DRAIN_TIMEOUT               = 1024,
  parameter int SETTLE_CYCLES               = 4
) (
  input  logic                                            ACLK,
  input  logic                                            ARESETN,
  input  logic                                            CMD_START,
  input  logic                                            CMD_STOP,
  input  logic                                            CFG_ACQUIRE_MODE,
  input  logic signed [SAMPLE_WIDTH-1:0]                  CFG_RISING_EDGE_THRESHOLD,
  input  logic signed [SAMPLE_WIDTH-1:0]                  CFG_FALLING_EDGE_THRESHOLD,
  input  logic [$clog2(MAX_PRE_ACQUISITION_LENGTH):0]     CFG_PRE_ACQUISITION_LENGTH,
  input  logic [$clog2(MAX_POST_ACQUISITION_LENGTH):0]    CFG_POST_ACQUISITION_LENGTH,
  input  logic                                            TRIG_TVALID,
  output logic                                            STOP,
  output logic                                            SET_CONFIG,
  output logic                                            ACQUIRE_MODE,
  output logic signed [SAMPLE_WIDTH-1:0]                  RISING_EDGE_THRESHOLD,
  output logic signed [SAMPLE_WIDTH-1:0]                  FALLING_EDGE_THRESHOLD,
  output logic [$clog2(MAX_PRE_ACQUISITION_LENGTH):0]     PRE_ACQUISITION_LENGTH,
  output logic [$clog2(MAX_POST_ACQUISITION_LENGTH):0]    POST_ACQUISITION_LENGTH,
  output logic                                            RUNNING,
  output logic                                            BUSY,
  output logic                                            CFG_ERROR,
  output logic                                            DRAIN_TIMEOUT_FLAG,
  output logic [2:0]                                      STATE
);

  localparam int PRE_W   = $clog2(MAX_PRE_ACQUISITION_LENGTH) + 1;
  localparam int POST_W  = $clog2(MAX_POST_ACQUISITION_LENGTH) + 1;
  localparam int CNT_MAX = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT : SETTLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] IDLE_LAST    = CW'(DRAIN_IDLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LATCH      = 3'd1,
    S_DRAIN      = 3'd2,
    S_CONFIG     = 3'd3,
    S_SETTLE     = 3'd4,
    S_RUN        = 3'd5,
    S_DRAIN_STOP = 3'd6
  } state_t;

  state_t state, next_state;

  // staged candidate configuration and where the command came from
  logic                           stg_mode;
  logic signed [SAMPLE_WIDTH-1:0] stg_rising;
  logic signed [SAMPLE_WIDTH-1:0] stg_falling;
  logic [PRE_W-1:0]               stg_pre;
  logic [POST_W-1:0]              stg_post;
  logic                           origin_run;

  logic [CW-1:0] dwell_cnt;
  logic [CW-1:0] idle_cnt;

  logic accept;
  logic next_origin;
  logic cfg_valid;
  logic idle_hit;
  logic timeout_hit;
  logic in_drain;
  logic stop_next, set_config_next, running_next, busy_next;

  assign cfg_valid = (int'(stg_pre) >= 1) && (int'(stg_pre) <= MAX_PRE_ACQUISITION_LENGTH) &&
                     (int'(stg_post) >= 1) && (int'(stg_post) <= MAX_POST_ACQUISITION_LENGTH) &&
                     (stg_falling <= stg_rising);

  assign in_drain    = (state == S_DRAIN) || (state == S_DRAIN_STOP);
  assign idle_hit    = !TRIG_TVALID && (idle_cnt == IDLE_LAST);
  assign timeout_hit = (dwell_cnt == TIMEOUT_LAST);
  assign STATE       = state;

  // state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= next_state;
  end

  // next state and the output values that go with it
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (CMD_START) begin
          next_state = S_LATCH;
          accept     = 1'b1;
        end
      end
      S_RUN: begin
        if (CMD_STOP) begin
          next_state = S_DRAIN_STOP;
        end else if (CMD_START) begin
          next_state = S_LATCH;
          accept     = 1'b1;
        end
      end
      S_LATCH: begin
        if (cfg_valid)       next_state = S_DRAIN;
        else if (origin_run) next_state = S_RUN;
        else                 next_state = S_IDLE;
      end
      S_DRAIN: begin
        if (idle_hit || timeout_hit) next_state = S_CONFIG;
      end
      S_DRAIN_STOP: begin
        if (idle_hit || timeout_hit) next_state = S_IDLE;
      end
      S_CONFIG: next_state = S_SETTLE;
      S_SETTLE: begin
        if (dwell_cnt == SETTLE_LAST) next_state = S_RUN;
      end
      default: next_state = S_IDLE;
    endcase

    next_origin = accept ? (state == S_RUN) : origin_run;
    // a rejected restart from RUN must never disturb the channel, so LATCH
    // keeps STOP low when the command came from RUN
    stop_next       = !((next_state == S_RUN) || ((next_state == S_LATCH) && next_origin));
    set_config_next = (next_state == S_CONFIG);
    running_next    = (next_state == S_RUN);
    busy_next       = !((next_state == S_IDLE) || (next_state == S_RUN));
  end

  // registered Moore outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      STOP       <= 1'b1;
      SET_CONFIG <= 1'b0;
      RUNNING    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      STOP       <= stop_next;
      SET_CONFIG <= set_config_next;
      RUNNING    <= running_next;
      BUSY       <= busy_next;
    end
  end

  // capture candidate config on an accepted start
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stg_mode    <= 1'b0;
      stg_rising  <= '0;
      stg_falling <= '0;
      stg_pre     <= '0;
      stg_post    <= '0;
      origin_run  <= 1'b0;
    end else if (accept) begin
      stg_mode    <= CFG_ACQUIRE_MODE;
      stg_rising  <= CFG_RISING_EDGE_THRESHOLD;
      stg_falling <= CFG_FALLING_EDGE_THRESHOLD;
      stg_pre     <= CFG_PRE_ACQUISITION_LENGTH;
      stg_post    <= CFG_POST_ACQUISITION_LENGTH;
      origin_run  <= (state == S_RUN);
    end
  end

  // applied config loads on the edge into CONFIG so it is stable under SET_CONFIG
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ACQUIRE_MODE            <= 1'b0;
      RISING_EDGE_THRESHOLD   <= SAMPLE_WIDTH'(1024);
      FALLING_EDGE_THRESHOLD  <= SAMPLE_WIDTH'(1024);
      PRE_ACQUISITION_LENGTH  <= PRE_W'(1);
      POST_ACQUISITION_LENGTH <= POST_W'(1);
    end else if ((state == S_DRAIN) && (next_state == S_CONFIG)) begin
      ACQUIRE_MODE            <= stg_mode;
      RISING_EDGE_THRESHOLD   <= stg_rising;
      FALLING_EDGE_THRESHOLD  <= stg_falling;
      PRE_ACQUISITION_LENGTH  <= stg_pre;
      POST_ACQUISITION_LENGTH <= stg_post;
    end
  end

  // dwell counter (drain timeout / settle length), cleared on every state entry
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                                 dwell_cnt <= '0;
    else if (next_state != state)                 dwell_cnt <= '0;
    else if (in_drain || (state == S_SETTLE))     dwell_cnt <= dwell_cnt + 1'b1;
  end

  // consecutive TVALID-low counter used to detect a drained output
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                 idle_cnt <= '0;
    else if (next_state != state) idle_cnt <= '0;
    else if (TRIG_TVALID)         idle_cnt <= '0;
    else if (in_drain)            idle_cnt <= idle_cnt + 1'b1;
  end

  // sticky status flags; a clean drain on the timeout cycle is not a timeout
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      CFG_ERROR          <= 1'b0;
      DRAIN_TIMEOUT_FLAG <= 1'b0;
    end else begin
      if (state == S_LATCH) CFG_ERROR <= !cfg_valid;
      if (in_drain && timeout_hit && !idle_hit) DRAIN_TIMEOUT_FLAG <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trigger_run_controller.sv
// tb/tb_trigger_run_controller.sv - directed self-checking bench for trigger_run_controller
module tb_trigger_run_controller;

  logic               ACLK = 1'b0;
  logic               ARESETN = 1'b0;
  logic               CMD_START = 1'b0;
  logic               CMD_STOP = 1'b0;
  logic               CFG_ACQUIRE_MODE = 1'b0;
  logic signed [15:0] CFG_RISING_EDGE_THRESHOLD = '0;
  logic signed [15:0] CFG_FALLING_EDGE_THRESHOLD = '0;
  logic [1:0]         CFG_PRE_ACQUISITION_LENGTH = '0;
  logic [1:0]         CFG_POST_ACQUISITION_LENGTH = '0;
  logic               TRIG_TVALID = 1'b0;
  logic               STOP, SET_CONFIG, ACQUIRE_MODE, RUNNING, BUSY, CFG_ERROR, DRAIN_TIMEOUT_FLAG;
  logic signed [15:0] RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD;
  logic [1:0]         PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH;
  logic [2:0]         STATE;

  int vectors = 0;
  int miscompares = 0;

  trigger_run_controller dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .CMD_START(CMD_START), .CMD_STOP(CMD_STOP),
    .CFG_ACQUIRE_MODE(CFG_ACQUIRE_MODE),
    .CFG_RISING_EDGE_THRESHOLD(CFG_RISING_EDGE_THRESHOLD),
    .CFG_FALLING_EDGE_THRESHOLD(CFG_FALLING_EDGE_THRESHOLD),
    .CFG_PRE_ACQUISITION_LENGTH(CFG_PRE_ACQUISITION_LENGTH),
    .CFG_POST_ACQUISITION_LENGTH(CFG_POST_ACQUISITION_LENGTH),
    .TRIG_TVALID(TRIG_TVALID), .STOP(STOP), .SET_CONFIG(SET_CONFIG),
    .ACQUIRE_MODE(ACQUIRE_MODE), .RISING_EDGE_THRESHOLD(RISING_EDGE_THRESHOLD),
    .FALLING_EDGE_THRESHOLD(FALLING_EDGE_THRESHOLD),
    .PRE_ACQUISITION_LENGTH(PRE_ACQUISITION_LENGTH),
    .POST_ACQUISITION_LENGTH(POST_ACQUISITION_LENGTH),
    .RUNNING(RUNNING), .BUSY(BUSY), .CFG_ERROR(CFG_ERROR),
    .DRAIN_TIMEOUT_FLAG(DRAIN_TIMEOUT_FLAG), .STATE(STATE)
  );

  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_cfg(input logic m, input logic [1:0] pre, input logic [1:0] post,
                         input logic signed [15:0] rise, input logic signed [15:0] fall);
    CFG_ACQUIRE_MODE            = m;
    CFG_PRE_ACQUISITION_LENGTH  = pre;
    CFG_POST_ACQUISITION_LENGTH = post;
    CFG_RISING_EDGE_THRESHOLD   = rise;
    CFG_FALLING_EDGE_THRESHOLD  = fall;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    #23;
    vectors++; if (STATE !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d exp 0", STATE); end
    vectors++; if (STOP !== 1'b1) begin miscompares++; $display("FAIL reset_stop got %0b exp 1", STOP); end
    step();
    ARESETN = 1'b1;
    step(); step();
    vectors++; if (STATE !== 3'd0) begin miscompares++; $display("FAIL idle_state got %0d exp 0", STATE); end
    vectors++; if (STOP !== 1'b1) begin miscompares++; $display("FAIL idle_stop got %0b exp 1", STOP); end
    vectors++; if (SET_CONFIG !== 1'b0) begin miscompares++; $display("FAIL idle_setcfg got %0b exp 0", SET_CONFIG); end
    vectors++; if (PRE_ACQUISITION_LENGTH !== 2'd1) begin miscompares++; $display("FAIL idle_pre got %0d exp 1", PRE_ACQUISITION_LENGTH); end
    vectors++; if (POST_ACQUISITION_LENGTH !== 2'd1) begin miscompares++; $display("FAIL idle_post got %0d exp 1", POST_ACQUISITION_LENGTH); end
    vectors++; if (RISING_EDGE_THRESHOLD !== 16'sd1024) begin miscompares++; $display("FAIL idle_rise got %0d exp 1024", RISING_EDGE_THRESHOLD); end
    vectors++; if (FALLING_EDGE_THRESHOLD !== 16'sd1024) begin miscompares++; $display("FAIL idle_fall got %0d exp 1024", FALLING_EDGE_THRESHOLD); end
    vectors++; if (ACQUIRE_MODE !== 1'b0) begin miscompares++; $display("FAIL idle_mode got %0b exp 0", ACQUIRE_MODE); end
    vectors++; if (CFG_ERROR !== 1'b0 || DRAIN_TIMEOUT_FLAG !== 1'b0) begin miscompares++; $display("FAIL idle_flags got %0b%0b exp 00", CFG_ERROR, DRAIN_TIMEOUT_FLAG); end
    vectors++; if (RUNNING !== 1'b0 || BUSY !== 1'b0) begin miscompares++; $display("FAIL idle_run_busy got %0b%0b exp 00", RUNNING, BUSY); end
  endtask

  task automatic test_start_idle();
    logic [2:0] exp_state;
    TRIG_TVALID = 1'b0;
    set_cfg(1'b1, 2'd2, 2'd2, 16'sd500, 16'sd300);
    CMD_START = 1'b1;
    step();
    CMD_START = 1'b0;
    set_cfg(1'b0, 2'd0, 2'd0, 16'sd7, 16'sd9);  // staging must already hold the accepted values
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) step();
      exp_state = (k == 1) ? 3'd1 : (k <= 9) ? 3'd2 : (k == 10) ? 3'd3 : (k <= 14) ? 3'd4 : 3'd5;
      vectors++; if (STATE !== exp_state) begin miscompares++; $display("FAIL start_state k=%0d got %0d exp %0d", k, STATE, exp_state); end
      vectors++; if (SET_CONFIG !== (k == 10)) begin miscompares++; $display("FAIL start_setcfg k=%0d got %0b exp %0b", k, SET_CONFIG, (k == 10)); end
      vectors++; if (STOP !== (k < 15)) begin miscompares++; $display("FAIL start_stop k=%0d got %0b exp %0b", k, STOP, (k < 15)); end
      vectors++; if (BUSY !== (k < 15)) begin miscompares++; $display("FAIL start_busy k=%0d got %0b exp %0b", k, BUSY, (k < 15)); end
      if (k == 9) begin
        vectors++; if (RISING_EDGE_THRESHOLD !== 16'sd1024) begin miscompares++; $display("FAIL start_early_rise got %0d exp 1024", RISING_EDGE_THRESHOLD); end
      end
      if (k == 10) begin
        vectors++; if (PRE_ACQUISITION_LENGTH !== 2'd2 || POST_ACQUISITION_LENGTH !== 2'd2) begin miscompares++; $display("FAIL start_prepost got %0d/%0d exp 2/2", PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH); end
        vectors++; if (RISING_EDGE_THRESHOLD !== 16'sd500 || FALLING_EDGE_THRESHOLD !== 16'sd300) begin miscompares++; $display("FAIL start_thresh got %0d/%0d exp 500/300", RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD); end
        vectors++; if (ACQUIRE_MODE !== 1'b1) begin miscompares++; $display("FAIL start_mode got %0b exp 1", ACQUIRE_MODE); end
      end
    end
    vectors++; if (RUNNING !== 1'b1) begin miscompares++; $display("FAIL start_running got %0b exp 1", RUNNING); end
  endtask

  task automatic test_drain_restart();
    logic [2:0] exp_state;
    set_cfg(1'b0, 2'd1, 2'd2, 16'sd100, -16'sd50);
    TRIG_TVALID = 1'b1;
    CMD_START = 1'b1;
    step();
    CMD_START = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) step();
      TRIG_TVALID = (k <= 3);
      exp_state = (k == 1) ? 3'd1 : (k <= 11) ? 3'd2 : (k == 12) ? 3'd3 : (k <= 16) ? 3'd4 : 3'd5;
      vectors++; if (STATE !== exp_state) begin miscompares++; $display("FAIL drain_state k=%0d got %0d exp %0d", k, STATE, exp_state); end
      vectors++; if (STOP !== (k >= 2 && k <= 16)) begin miscompares++; $display("FAIL drain_stop k=%0d got %0b exp %0b", k, STOP, (k >= 2 && k <= 16)); end
      vectors++; if (SET_CONFIG !== (k == 12)) begin miscompares++; $display("FAIL drain_setcfg k=%0d got %0b exp %0b", k, SET_CONFIG, (k == 12)); end
      if (k == 12) begin
        vectors++; if (RISING_EDGE_THRESHOLD !== 16'sd100 || FALLING_EDGE_THRESHOLD !== -16'sd50) begin miscompares++; $display("FAIL drain_thresh got %0d/%0d exp 100/-50", RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD); end
        vectors++; if (PRE_ACQUISITION_LENGTH !== 2'd1 || POST_ACQUISITION_LENGTH !== 2'd2) begin miscompares++; $display("FAIL drain_prepost got %0d/%0d exp 1/2", PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH); end
      end
    end
    TRIG_TVALID = 1'b0;
  endtask

  task automatic test_invalid_cfg();
    for (int c = 0; c < 3; c++) begin
      case (c)
        0:       set_cfg(1'b1, 2'd0, 2'd1, 16'sd500, 16'sd300);  // pre below 1
        1:       set_cfg(1'b1, 2'd2, 2'd3, 16'sd500, 16'sd300);  // post above max
        default: set_cfg(1'b1, 2'd2, 2'd2, 16'sd500, 16'sd600);  // falling above rising
      endcase
      CMD_START = 1'b1;
      step();
      CMD_START = 1'b0;
      vectors++; if (STATE !== 3'd1) begin miscompares++; $display("FAIL inv%0d_latch got %0d exp 1", c, STATE); end
      vectors++; if (STOP !== 1'b0) begin miscompares++; $display("FAIL inv%0d_latch_stop got %0b exp 0", c, STOP); end
      step();
      vectors++; if (STATE !== 3'd5) begin miscompares++; $display("FAIL inv%0d_back got %0d exp 5", c, STATE); end
      vectors++; if (STOP !== 1'b0 || SET_CONFIG !== 1'b0) begin miscompares++; $display("FAIL inv%0d_ctl got %0b%0b exp 00", c, STOP, SET_CONFIG); end
      vectors++; if (CFG_ERROR !== 1'b1) begin miscompares++; $display("FAIL inv%0d_err got %0b exp 1", c, CFG_ERROR); end
      vectors++; if (PRE_ACQUISITION_LENGTH !== 2'd1 || RISING_EDGE_THRESHOLD !== 16'sd100 || ACQUIRE_MODE !== 1'b0) begin miscompares++; $display("FAIL inv%0d_cfg got %0d/%0d/%0b exp 1/100/0", c, PRE_ACQUISITION_LENGTH, RISING_EDGE_THRESHOLD, ACQUIRE_MODE); end
      step();
    end
  endtask

  task automatic test_stop_vs_start();
    int pulses = 0;
    set_cfg(1'b1, 2'd2, 2'd2, 16'sd50, 16'sd40);
    TRIG_TVALID = 1'b1;
    CMD_START = 1'b1;
    CMD_STOP = 1'b1;
    step();
    CMD_START = 1'b0;
    CMD_STOP = 1'b0;
    vectors++; if (STATE !== 3'd6) begin miscompares++; $display("FAIL stop_state got %0d exp 6", STATE); end
    vectors++; if (STOP !== 1'b1) begin miscompares++; $display("FAIL stop_stop got %0b exp 1", STOP); end
    for (int k = 2; k <= 1024; k++) begin
      step();
      pulses += int'(SET_CONFIG);
    end
    vectors++; if (STATE !== 3'd6 || DRAIN_TIMEOUT_FLAG !== 1'b0) begin miscompares++; $display("FAIL stop_last_dwell got %0d/%0b exp 6/0", STATE, DRAIN_TIMEOUT_FLAG); end
    step();
    vectors++; if (STATE !== 3'd0) begin miscompares++; $display("FAIL stop_idle got %0d exp 0", STATE); end
    vectors++; if (DRAIN_TIMEOUT_FLAG !== 1'b1) begin miscompares++; $display("FAIL stop_tflag got %0b exp 1", DRAIN_TIMEOUT_FLAG); end
    vectors++; if (pulses !== 0 || SET_CONFIG !== 1'b0) begin miscompares++; $display("FAIL stop_pulses got %0d exp 0", pulses); end
    vectors++; if (RUNNING !== 1'b0 || STOP !== 1'b1) begin miscompares++; $display("FAIL stop_ctl got %0b%0b exp 01", RUNNING, STOP); end
    vectors++; if (RISING_EDGE_THRESHOLD !== 16'sd100) begin miscompares++; $display("FAIL stop_cfg got %0d exp 100", RISING_EDGE_THRESHOLD); end
    TRIG_TVALID = 1'b0;
  endtask

  task automatic test_busy_reset();
    int pulses = 0;
    set_cfg(1'b1, 2'd2, 2'd1, 16'sd10, 16'sd10);
    CMD_START = 1'b1;
    step();
    CMD_START = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) step();
      if (k == 12) begin
        set_cfg(1'b0, 2'd1, 2'd2, 16'sd2000, 16'sd0);
        CMD_START = 1'b1;
      end
      if (k == 13) CMD_START = 1'b0;
      pulses += int'(SET_CONFIG);
      if (k == 2) begin
        vectors++; if (CFG_ERROR !== 1'b0 || STATE !== 3'd2) begin miscompares++; $display("FAIL busy_errclr got %0b/%0d exp 0/2", CFG_ERROR, STATE); end
      end
      if (k == 12) begin
        vectors++; if (STATE !== 3'd4) begin miscompares++; $display("FAIL busy_settle got %0d exp 4", STATE); end
      end
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL busy_pulses got %0d exp 1", pulses); end
    vectors++; if (STATE !== 3'd5) begin miscompares++; $display("FAIL busy_run got %0d exp 5", STATE); end
    vectors++; if (PRE_ACQUISITION_LENGTH !== 2'd2 || RISING_EDGE_THRESHOLD !== 16'sd10 || FALLING_EDGE_THRESHOLD !== 16'sd10) begin miscompares++; $display("FAIL busy_cfg got %0d/%0d/%0d exp 2/10/10", PRE_ACQUISITION_LENGTH, RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD); end
    vectors++; if (DRAIN_TIMEOUT_FLAG !== 1'b1) begin miscompares++; $display("FAIL busy_tflag_sticky got %0b exp 1", DRAIN_TIMEOUT_FLAG); end

    set_cfg(1'b1, 2'd2, 2'd2, 16'sd7, 16'sd3);
    TRIG_TVALID = 1'b1;
    CMD_START = 1'b1;
    step();
    CMD_START = 1'b0;
    step(); step();
    vectors++; if (STATE !== 3'd2) begin miscompares++; $display("FAIL rst_pre_drain got %0d exp 2", STATE); end
    ARESETN = 1'b0;
    #1;
    vectors++; if (STATE !== 3'd0 || STOP !== 1'b1 || BUSY !== 1'b0) begin miscompares++; $display("FAIL rst_async got %0d/%0b/%0b exp 0/1/0", STATE, STOP, BUSY); end
    vectors++; if (PRE_ACQUISITION_LENGTH !== 2'd1 || POST_ACQUISITION_LENGTH !== 2'd1 || ACQUIRE_MODE !== 1'b0) begin miscompares++; $display("FAIL rst_prepost got %0d/%0d/%0b exp 1/1/0", PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH, ACQUIRE_MODE); end
    vectors++; if (RISING_EDGE_THRESHOLD !== 16'sd1024 || FALLING_EDGE_THRESHOLD !== 16'sd1024) begin miscompares++; $display("FAIL rst_thresh got %0d/%0d exp 1024/1024", RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD); end
    vectors++; if (DRAIN_TIMEOUT_FLAG !== 1'b0 || CFG_ERROR !== 1'b0) begin miscompares++; $display("FAIL rst_flags got %0b%0b exp 00", DRAIN_TIMEOUT_FLAG, CFG_ERROR); end
    #2;
    ARESETN = 1'b1;
    TRIG_TVALID = 1'b0;
    for (int k = 0; k < 12; k++) step();
    vectors++; if (STATE !== 3'd0 || SET_CONFIG !== 1'b0 || PRE_ACQUISITION_LENGTH !== 2'd1) begin miscompares++; $display("FAIL rst_discard got %0d/%0b/%0d exp 0/0/1", STATE, SET_CONFIG, PRE_ACQUISITION_LENGTH); end
  endtask

  initial begin
    test_reset();
    test_start_idle();
    test_drain_restart();
    test_invalid_cfg();
    test_stop_vs_start();
    test_busy_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trigger_run_controller.md
Name: trigger_run_controller

Overview:
Run-control sequencer for one data_trigger channel. Accepts start/stop/apply commands plus a candidate trigger configuration from the slow-control side, validates it, and drives data_trigger's STOP, SET_CONFIG and configuration inputs. Before every reconfiguration it stops the channel, waits for the trigger output to drain, pulses SET_CONFIG once, and waits for the pipeline to settle before releasing STOP. It sits between the PS-side register block and data_trigger; it monitors data_trigger's M_AXIS_TVALID.

Parameters:
MAX_PRE_ACQUISITION_LENGTH, 2, upper legal bound of pre-acquisition length; must match data_trigger
MAX_POST_ACQUISITION_LENGTH, 2, upper legal bound of post-acquisition length; must match data_trigger
SAMPLE_WIDTH, 16, threshold width (signed)
DRAIN_IDLE_CYCLES, 8, consecutive TVALID-low cycles that define "drained" (>=1)
DRAIN_TIMEOUT, 1024, maximum cycles spent in DRAIN
SETTLE_CYCLES, 4, cycles held stopped after SET_CONFIG (>= MAX_PRE_ACQUISITION_LENGTH+2)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
CMD_START  in  1  start; in RUN it means apply the new config
CMD_STOP  in  1  stop run
CFG_ACQUIRE_MODE  in  1  candidate acquire mode
CFG_RISING_EDGE_THRESHOLD  in  SAMPLE_WIDTH  candidate threshold, signed
CFG_FALLING_EDGE_THRESHOLD  in  SAMPLE_WIDTH  candidate threshold, signed
CFG_PRE_ACQUISITION_LENGTH  in  $clog2(MAX_PRE_ACQUISITION_LENGTH)+1  candidate pre-acquisition length
CFG_POST_ACQUISITION_LENGTH  in  $clog2(MAX_POST_ACQUISITION_LENGTH)+1  candidate post-acquisition length
TRIG_TVALID  in  1  data_trigger M_AXIS_TVALID
STOP  out  1  to data_trigger STOP
SET_CONFIG  out  1  to data_trigger SET_CONFIG; one-cycle pulse
ACQUIRE_MODE, RISING_EDGE_THRESHOLD, FALLING_EDGE_THRESHOLD, PRE_ACQUISITION_LENGTH, POST_ACQUISITION_LENGTH  out  same widths as the CFG_ inputs  applied configuration
RUNNING  out  1  state==RUN
BUSY  out  1  state not in {IDLE, RUN}
CFG_ERROR  out  1  sticky: last candidate was rejected
DRAIN_TIMEOUT_FLAG  out  1  sticky: a drain ended by timeout
STATE  out  3  debug state encoding

Behaviour:
- Reset (ARESETN low, asynchronous):
  - state IDLE; STOP=1; SET_CONFIG=0; RUNNING=0; BUSY=0; both sticky flags 0.
  - Applied config = ACQUIRE_MODE 0, pre 1, post 1, both thresholds 1024.
- All outputs are registered and decoded from state (Moore). STOP=1 in every state except RUN. SET_CONFIG=1 only in CONFIG.
- States: IDLE=0, LATCH=1, DRAIN=2, CONFIG=3, SETTLE=4, RUN=5, DRAIN_STOP=6.
- Command accept:
  - In IDLE or RUN, CMD_START=1 captures all CFG_* inputs into staging registers and moves to LATCH. The origin state (IDLE or RUN) is recorded.
  - In RUN, CMD_STOP=1 moves to DRAIN_STOP.
  - If CMD_START and CMD_STOP are both 1 in RUN, stop wins.
  - In IDLE, CMD_STOP is ignored.
  - In any busy state, all commands are ignored (no queuing).
- LATCH (1 cycle) validates the staged config. It is valid iff all of:
  - 1 <= pre <= MAX_PRE_ACQUISITION_LENGTH
  - 1 <= post <= MAX_POST_ACQUISITION_LENGTH
  - falling <= rising (signed compare)
  - Valid: go to DRAIN and clear CFG_ERROR.
  - Invalid: set CFG_ERROR and return to the origin state. The applied config is unchanged. A RUN origin returns to RUN without STOP ever asserting.
- DRAIN / DRAIN_STOP:
  - Idle counter counts consecutive cycles with TVALID=0; TVALID=1 clears it.
  - Exit on the cycle where the counter reaches DRAIN_IDLE_CYCLES-1 and TVALID=0.
  - Independently, a dwell counter forces exit after DRAIN_TIMEOUT cycles and sets DRAIN_TIMEOUT_FLAG.
  - DRAIN exits to CONFIG. DRAIN_STOP exits to IDLE.
- CONFIG (1 cycle):
  - Applied-config registers load from staging on the edge entering CONFIG, so they are stable while SET_CONFIG=1.
  - Next state is SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles, then go to RUN.
- Applied-config outputs change only on entry to CONFIG.
- Counter width: $clog2 of the larger of DRAIN_TIMEOUT and SETTLE_CYCLES, plus 1. Counters reset on every state entry.
- Latency from accepted CMD_START at edge t, TVALID=0 throughout, default parameters:
  - LATCH in cycle t+1
  - DRAIN t+2..t+9
  - CONFIG t+10
  - SETTLE t+11..t+14
  - RUN, STOP=0, from t+15
- Reset mid-sequence returns to IDLE immediately with reset values. Any partially staged config is discarded.

Test Plan:
- Reset: ARESETN low, then release; no commands -> STOP=1, SET_CONFIG=0, PRE/POST=1, thresholds=1024, STATE=0, both flags 0.
- Start from IDLE: CMD_START one cycle at t, CFG pre=2, post=2, rising=500, falling=300, TVALID=0 -> SET_CONFIG high only at t+10 with new config already on outputs; STOP falls at t+15; RUNNING=1.
- Drain restart in RUN: CMD_START with TVALID=1 until 3 cycles after the command, then 0 -> CONFIG exactly 8 consecutive low-TVALID cycles after TVALID falls; STOP=1 from LATCH+1 until end of SETTLE.
- Invalid config from RUN: pre=0 (or falling=600 > rising=500) -> CFG_ERROR=1, back to RUN after 1 LATCH cycle, STOP never asserts, config outputs unchanged.
- Stop vs start: CMD_START and CMD_STOP both high in RUN with TVALID stuck at 1 -> DRAIN_STOP; after 1024 cycles IDLE with DRAIN_TIMEOUT_FLAG=1 and no SET_CONFIG pulse.
- Busy/reset: CMD_START during SETTLE is ignored (one SET_CONFIG pulse only); ARESETN low during DRAIN -> immediate IDLE with default config.
